// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash responder.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        IGNORE
    } state_e;

    localparam logic [7:0] READ_CMD_DEFAULT = 8'h03;

    localparam int CMD_CNT_W  = 3;
    localparam int ADDR_CNT_W = 5;
    localparam int DATA_CNT_W = 5;
    localparam int WORD_W     = 32;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus registered SCK edge detection.
// rise/fall and the aligned MOSI sample appear three clocks after the pins move.
module spi_pin_sync (
    input  logic clock,
    input  logic reset,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic ss_sync,
    output logic ss_live,
    output logic mosi_sync,
    output logic rise,
    output logic fall
);

    logic sck_p0;
    logic sck_p1;
    logic sck_p2;
    logic ss_p0;
    logic fill_p0;
    logic mosi_p0;
    logic mosi_p1;

    // Control pins: SCK/SS synchronizers, SCK edge register, and a fill marker
    // that says when ss_sync holds a real pin sample rather than its reset value.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_p0  <= 1'b0;
            sck_p1  <= 1'b0;
            sck_p2  <= 1'b0;
            ss_p0   <= 1'b1;
            ss_sync <= 1'b1;
            fill_p0 <= 1'b0;
            ss_live <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            // stage p0 -> p1: metastability settling
            sck_p0  <= sck;
            sck_p1  <= sck_p0;
            ss_p0   <= ss;
            ss_sync <= ss_p0;
            fill_p0 <= 1'b1;
            ss_live <= fill_p0;
            // stage p1 -> p2: edge register
            sck_p2  <= sck_p1;
            rise    <= sck_p1 & ~sck_p2;
            fall    <= ~sck_p1 & sck_p2;
        end
    end

    // MOSI data path: one extra stage so the sample lines up with the rise pulse.
    always_ff @(posedge clock) begin
        mosi_p0   <= mosi;
        mosi_p1   <= mosi_p0;
        mosi_sync <= mosi_p1;
    end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: decodes READ (0x03) + address, fetches 32-bit
// words from a 1-cycle-latency memory port and streams them on MISO with a
// mid-word prefetch so consecutive words follow without gaps.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [7:0] READ_CMD = READ_CMD_DEFAULT,
    parameter int          ADDR_W   = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [CMD_CNT_W-1:0]  CMD_LAST    = '1;
    localparam logic [ADDR_CNT_W-1:0] ADDR_LAST   = ADDR_CNT_W'(ADDR_W - 1);
    localparam logic [DATA_CNT_W-1:0] DATA_LAST   = '1;
    localparam logic [DATA_CNT_W-1:0] PREFETCH_AT = DATA_CNT_W'(15);
    localparam logic [ADDR_W-1:0]     WORD_STEP   = ADDR_W'(4);

    logic ss_s;
    logic ss_live;
    logic mosi_s;
    logic rise;
    logic fall;

    state_e state;
    state_e state_nx;

    logic armed;
    logic [CMD_CNT_W-1:0]  cmd_cnt;
    logic [ADDR_CNT_W-1:0] addr_cnt;
    logic [DATA_CNT_W-1:0] data_cnt;

    logic [6:0]        cmd_sh;
    logic [ADDR_W-2:0] addr_sh;
    logic [7:0]        cmd_byte;
    logic [ADDR_W-1:0] addr_full;
    logic [WORD_W-1:0] tx_sh;
    logic [WORD_W-1:0] hold;

    logic go_first;
    logic go_next;
    logic err_nx;
    logic fetch_first_p1;
    logic fetch_first_p2;
    logic fetch_next_p1;
    logic fetch_next_p2;

    spi_pin_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .sck       (spi_sck),
        .ss        (spi_ss),
        .mosi      (spi_mosi),
        .ss_sync   (ss_s),
        .ss_live   (ss_live),
        .mosi_sync (mosi_s),
        .rise      (rise),
        .fall      (fall)
    );

    assign busy      = ~ss_s;
    assign cmd_byte  = {cmd_sh, mosi_s};
    assign addr_full = {addr_sh, mosi_s};

    // Next-state and one-cycle strobes; SS high overrides everything, including a coincident rise.
    always_comb begin
        state_nx = state;
        go_first = 1'b0;
        go_next  = 1'b0;
        err_nx   = 1'b0;
        if (ss_s) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (armed) state_nx = CMD;
                end
                CMD: begin
                    if (rise && cmd_cnt == CMD_LAST) begin
                        if (cmd_byte == READ_CMD) begin
                            state_nx = ADDR;
                        end else begin
                            err_nx   = 1'b1;
                            state_nx = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (rise && addr_cnt == ADDR_LAST) begin
                        go_first = 1'b1;
                        state_nx = DATA;
                    end
                end
                DATA: begin
                    if (fall && data_cnt == PREFETCH_AT) go_next = 1'b1;
                end
                IGNORE: begin
                    state_nx = IGNORE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Control state: FSM register, bit counters, memory strobe/address, MISO pin and error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            armed          <= 1'b0;
            cmd_cnt        <= '0;
            addr_cnt       <= '0;
            data_cnt       <= '0;
            mem_ren        <= 1'b0;
            mem_addr       <= '0;
            cmd_err        <= 1'b0;
            spi_miso       <= 1'b1;
            fetch_first_p1 <= 1'b0;
            fetch_first_p2 <= 1'b0;
            fetch_next_p1  <= 1'b0;
            fetch_next_p2  <= 1'b0;
        end else begin
            state   <= state_nx;
            armed   <= armed | (ss_s & ss_live);
            cmd_err <= err_nx;
            // stage p0 -> p1: read strobe issued
            mem_ren        <= go_first | go_next;
            fetch_first_p1 <= go_first;
            fetch_next_p1  <= go_next;
            // stage p1 -> p2: read data valid on the port
            fetch_first_p2 <= fetch_first_p1;
            fetch_next_p2  <= fetch_next_p1;
            if (go_first) begin
                mem_addr <= {addr_full[ADDR_W-1:2], 2'b00};
            end else if (go_next) begin
                mem_addr <= mem_addr + WORD_STEP;
            end
            if (ss_s) begin
                cmd_cnt  <= '0;
                addr_cnt <= '0;
                data_cnt <= '0;
                spi_miso <= 1'b1;
            end else begin
                if (state == CMD && rise) cmd_cnt <= cmd_cnt + CMD_CNT_W'(1);
                if (state == ADDR && rise) addr_cnt <= addr_cnt + ADDR_CNT_W'(1);
                if (state == DATA) begin
                    if (fall) begin
                        data_cnt <= data_cnt + DATA_CNT_W'(1);
                        spi_miso <= tx_sh[WORD_W-1];
                    end
                end else begin
                    spi_miso <= 1'b1;
                end
            end
        end
    end

    // Data shift registers: MOSI capture, MISO word shifter and prefetch holding register.
    always_ff @(posedge clock) begin
        if (state == CMD && rise) cmd_sh <= cmd_byte[6:0];
        if (state == ADDR && rise) addr_sh <= addr_full[ADDR_W-2:0];
        if (fetch_first_p2) begin
            tx_sh <= mem_rdata;
        end else if (state == DATA && fall) begin
            // the 32nd bit goes out now; the prefetched word takes its place
            tx_sh <= (data_cnt == DATA_LAST) ? hold : {tx_sh[WORD_W-2:0], 1'b0};
        end
        if (fetch_next_p2) hold <= mem_rdata;
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: stimulus pushes expected memory
// reads, error pulses and MISO words; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_spi_flash_responder;

    localparam int HALF = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        spi_sck;
    logic        spi_ss;
    logic        spi_mosi;
    logic        spi_miso;
    logic        mem_ren;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        cmd_err;

    always #5 clock = ~clock;

    spi_flash_responder dut (
        .clock     (clock),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    typedef struct {
        logic [23:0] addr;
        int          pos;
    } ren_t;

    ren_t        exp_ren_q[$];
    logic [31:0] exp_word_q[$];
    int          exp_err_q[$];

    int          total = 0;
    int          bad = 0;
    int          data_falls = 0;
    bit          data_phase = 1'b0;
    logic [31:0] rx_word = '0;
    bit          rx_vld = 1'b0;
    logic        ren_prev = 1'b0;

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        case (a)
            24'h000010: return 32'hDEADBEEF;
            24'h000014: return 32'h01234567;
            24'h000018: return 32'h89ABCDEF;
            24'hFFFFFC: return 32'hCAFEF00D;
            24'h000000: return 32'h13579BDF;
            24'h000020: return 32'hA5A55A5A;
            default:    return {8'hEE, a};
        endcase
    endfunction

    // backing memory: registered read, data valid the cycle after mem_ren
    always @(posedge clock) begin
        if (mem_ren) mem_rdata <= mem_word(mem_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_ren(input logic [23:0] a, input int pos);
        ren_t e;
        e.addr = a;
        e.pos  = pos;
        exp_ren_q.push_back(e);
    endtask

    // mode-0 master: falling edge at the start of each bit, MISO sampled on the rising edge
    task automatic spi_bits(input logic [31:0] tx, input int n, input bit collect);
        logic [31:0] rx;
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_sck  = 1'b0;
            spi_mosi = tx[i];
            if (data_phase) data_falls++;
            tick(HALF);
            spi_sck = 1'b1;
            rx = {rx[30:0], spi_miso};
            tick(HALF);
        end
        if (collect) begin
            rx_word = rx;
            rx_vld  = 1'b1;
            tick(1);
            rx_vld  = 1'b0;
        end
    endtask

    task automatic ss_begin();
        data_falls = 0;
        spi_ss = 1'b0;
        tick(4);
    endtask

    task automatic ss_end();
        data_phase = 1'b0;
        spi_sck = 1'b0;
        tick(HALF);
        spi_ss = 1'b1;
        tick(8);
    endtask

    task automatic send_read(input logic [23:0] a);
        spi_bits(32'h03, 8, 1'b0);
        spi_bits({8'h00, a}, 24, 1'b0);
        data_phase = 1'b1;
    endtask

    // monitor: compares every DUT-presented event against the expected queues
    always @(negedge clock) begin
        if (mem_ren) begin
            if (exp_ren_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ren: got addr %0h expected no read", mem_addr);
            end else begin
                ren_t e;
                e = exp_ren_q.pop_front();
                check("ren_addr", {40'd0, mem_addr}, {40'd0, e.addr});
                check("ren_bitpos", data_falls % 32, e.pos);
                check("ren_back_to_back", {63'd0, ren_prev}, 64'd0);
            end
        end
        if (cmd_err) begin
            if (exp_err_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_cmd_err: got pulse expected none");
            end else begin
                void'(exp_err_q.pop_front());
                total++;
            end
        end
        if (rx_vld) begin
            if (exp_word_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h expected none", rx_word);
            end else begin
                check("miso_word", {32'd0, rx_word}, {32'd0, exp_word_q.pop_front()});
            end
        end
        ren_prev = mem_ren;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        spi_sck  = 1'b0;
        spi_ss   = 1'b1;
        spi_mosi = 1'b0;
        tick(3);
        check("rst_miso", {63'd0, spi_miso}, 64'd1);
        check("rst_ren", {63'd0, mem_ren}, 64'd0);
        check("rst_addr", {40'd0, mem_addr}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_cmd_err", {63'd0, cmd_err}, 64'd0);
        reset = 1'b0;
        tick(1);
        check("post_rst_miso", {63'd0, spi_miso}, 64'd1);
        check("post_rst_busy", {63'd0, busy}, 64'd0);
        tick(4);

        // basic read at 0x10 followed by two streamed words
        push_ren(24'h000010, 0);
        push_ren(24'h000014, 16);
        push_ren(24'h000018, 16);
        push_ren(24'h00001C, 16);
        exp_word_q.push_back(32'hDEADBEEF);
        exp_word_q.push_back(32'h01234567);
        exp_word_q.push_back(32'h89ABCDEF);
        ss_begin();
        check("busy_active", {63'd0, busy}, 64'd1);
        send_read(24'h000010);
        repeat (3) spi_bits(32'h0, 32, 1'b1);
        ss_end();
        check("busy_idle", {63'd0, busy}, 64'd0);

        // wrap: low address bits are dropped, 0xFFFFFC + 4 wraps to 0
        push_ren(24'hFFFFFC, 0);
        push_ren(24'h000000, 16);
        push_ren(24'h000004, 16);
        exp_word_q.push_back(32'hCAFEF00D);
        exp_word_q.push_back(32'h13579BDF);
        ss_begin();
        send_read(24'hFFFFFF);
        repeat (2) spi_bits(32'h0, 32, 1'b1);
        ss_end();

        // bad command: one error pulse, no read, MISO held high
        exp_err_q.push_back(1);
        exp_word_q.push_back(32'hFFFFFFFF);
        ss_begin();
        spi_bits(32'h9F, 8, 1'b0);
        spi_bits(32'h03000010, 32, 1'b1);
        ss_end();

        // abort after 12 address bits, then a clean read at 0x20
        ss_begin();
        spi_bits(32'h03, 8, 1'b0);
        spi_bits(32'h000, 12, 1'b0);
        ss_end();
        push_ren(24'h000020, 0);
        push_ren(24'h000024, 16);
        exp_word_q.push_back(32'hA5A55A5A);
        ss_begin();
        send_read(24'h000020);
        spi_bits(32'h0, 32, 1'b1);
        ss_end();

        // reset in the middle of streaming
        push_ren(24'h000010, 0);
        push_ren(24'h000014, 16);
        ss_begin();
        send_read(24'h000010);
        spi_bits(32'h0, 20, 1'b0);
        data_phase = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_miso", {63'd0, spi_miso}, 64'd1);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        exp_word_q.push_back(32'hFFFFFFFF);
        spi_bits(32'h03000010, 32, 1'b1);
        ss_end();
        push_ren(24'h000014, 0);
        push_ren(24'h000018, 16);
        exp_word_q.push_back(32'h01234567);
        ss_begin();
        send_read(24'h000014);
        spi_bits(32'h0, 32, 1'b1);
        ss_end();

        tick(20);
        check("ren_q_drained", exp_ren_q.size(), 64'd0);
        check("err_q_drained", exp_err_q.size(), 64'd0);
        check("word_q_drained", exp_word_q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI flash responder: the device end of the SPI link driven by the SPI master in the APB flash path. It decodes mode-0 SPI transactions on one slave-select line, accepts the standard read command (0x03) with a 24-bit address, fetches 32-bit words from a backing memory port and streams them back on MISO. It serves as the flash model in SoC simulation and FPGA builds, and as the loopback target for SPI master verification.

## Interface
- `READ_CMD`, 8'h03: the only command served.
- `ADDR_W`, 24: address width, in bits, shifted after the command.
- `clock`, in, 1: the single clock. SPI pins are oversampled on it.
- `reset`, in, 1: synchronous, active-high.
- `spi_sck`, in, 1: SPI clock from the master. Asynchronous to `clock`.
- `spi_ss`, in, 1: slave select, active-low.
- `spi_mosi`, in, 1: master-out data.
- `spi_miso`, out, 1: slave-out data.
- `mem_ren`, out, 1: one-cycle read strobe to the backing memory.
- `mem_addr`, out, ADDR_W: word-aligned byte address; bits [1:0] are always 0.
- `mem_rdata`, in, 32: read data, valid exactly one `clock` after `mem_ren`.
- `busy`, out, 1: high while `spi_ss` (synchronized) is low.
- `cmd_err`, out, 1: one-cycle pulse when the command byte is not `READ_CMD`.

## Operation
- Synchronize `spi_sck`, `spi_ss` and `spi_mosi` through two flops each. Detect edges on the synchronized `sck`; `rise` and `fall` are single-cycle pulses.
- SPI mode 0:
  - On `rise`, sample `spi_mosi` MSB-first.
  - On `fall`, advance `spi_miso`.
- States:
  - **IDLE**: `spi_miso` = 1. Go to CMD when synchronized `ss` goes low.
  - **CMD**: shift 8 bits. On the 8th `rise`, go to ADDR if the byte equals `READ_CMD`. Otherwise pulse `cmd_err` and go to IGNORE.
  - **ADDR**: shift ADDR_W bits. On the last `rise`:
    - Latch the address.
    - Assert `mem_ren` with `mem_addr` = {addr[ADDR_W-1:2], 2'b00}.
    - Load `mem_rdata` into the 32-bit output shift register on the next cycle.
    - Go to DATA.
  - **DATA**:
    - Each `fall` (including the first after the last address bit) drives the next bit, MSB first.
    - When 16 bits of the current word have been driven, issue a prefetch: `mem_ren` with `mem_addr`+4, modulo 2^ADDR_W. 0xFFFFFC wraps to 0x000000.
    - Capture the prefetched word into a holding register.
    - After the 32nd bit, the holding register feeds the shift register. Streaming continues indefinitely.
  - **IGNORE**: `spi_miso` = 1, MOSI is discarded, until `ss` goes high.
- Synchronized `ss` high in any state: return to IDLE on the next cycle, `spi_miso` = 1, and clear all bit counters. A partial byte or word is discarded.
- Address bits [1:0] are ignored; reads are always word-aligned.
- `busy` is the inverted synchronized `ss`.

## Timing
- Values during and after reset:
  - `spi_miso` = 1, `mem_ren` = 0, `mem_addr` = 0.
  - `busy` = 0, `cmd_err` = 0.
  - State IDLE.
- A `reset` asserted mid-transaction aborts the transaction. The responder ignores SPI activity until `ss` has been seen high at least once after reset is released.
- Pin-to-action latency: 3 `clock` cycles (2 synchronizer stages plus the edge register).
- SCK high time and low time must each be at least 4 `clock` cycles. This guarantees:
  - `mem_rdata` lands in the shift register before the first data `fall` is acted upon;
  - `spi_miso` settles before the master's next rising edge.
- Memory port: fixed 1-cycle read latency, no back-pressure. `mem_ren` is never asserted on two consecutive cycles.
- `rise` and `ss` deassertion in the same cycle: deassertion wins and the bit is dropped.
- `cmd_err` asserts in the cycle after the 8th `rise`.

## Structure
- A shared package `spi_flash_pkg` holds:
  - the state enum (IDLE, CMD, ADDR, DATA, IGNORE);
  - `READ_CMD_DEFAULT`;
  - the counter widths (cmd 3 bits, addr 5 bits, data 5 bits).
- One sub-module, `spi_pin_sync`, contains the 2-flop synchronizers for the three inputs plus SCK rise/fall detection. The FSM, shift registers and prefetch logic stay in the top module.

## Test plan
- **Basic read:** with ss low, send 0x03, then 0x000010, then clock 32 bits; memory word at 0x10 = 0xDEADBEEF. Required: one `mem_ren` with `mem_addr` = 0x000010, and MISO returns 0xDEADBEEF MSB-first.
- **Streaming:** after the basic read, keep clocking 64 more bits; words at 0x14 = 0x01234567 and 0x18 = 0x89ABCDEF. Required: both words arrive back-to-back with no gap bits, and each prefetch `mem_ren` fires at bit 16 of the preceding word.
- **Address wrap:** read at 0xFFFFFC, then continue clocking. Required: the second fetch has `mem_addr` = 0x000000.
- **Bad command:** send 0x9F. Required: `cmd_err` pulses once, `mem_ren` never fires, and `spi_miso` stays 1 until ss goes high.
- **Abort:** deassert ss after 12 address bits, then start a fresh 0x03 read at 0x000020. Required: the first transaction does not fetch; the second fetches 0x000020 and returns correct data.
- **Reset mid-DATA:** assert `reset` for 1 cycle while data is streaming. Required: `spi_miso` = 1 and `busy` = 0 on the next cycle; no `mem_ren` fires until a new transaction begins after ss has been seen high.
